// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets several byte sources share one async_transmitter.
// A granted requester keeps the transmitter until it sends a byte flagged last or stalls too long.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [2:0]           grant_id,
    output logic                 active,
    output logic                 lock_timeout
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(LOCK_TIMEOUT) + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_IDLE,
        HOLD
    } stateT;

    stateT              state;
    stateT              nextState;
    logic [PTR_W-1:0]   rrPtr;
    logic [PTR_W-1:0]   grantQ;
    logic [PTR_W-1:0]   sel;
    logic [PTR_W-1:0]   acceptIdx;
    logic [PTR_W-1:0]   nextPtr;
    logic [CNT_W-1:0]   holdCnt;
    logic               lastQ;
    logic               anyValid;
    logic               handshake;
    logic               timeoutHit;
    logic               releaseLast;
    logic [NUM_REQ-1:0] readyVec;
    logic [7:0]         reqBytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign reqBytes[g] = req_data[8*g +: 8];
    end

    // Round-robin scan starting at rrPtr; first valid requester wins.
    always_comb begin
        int idx;
        idx      = 0;
        sel      = rrPtr;
        anyValid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rrPtr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!anyValid && req_valid[PTR_W'(idx)]) begin
                anyValid = 1'b1;
                sel      = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        readyVec = '0;
        case (state)
            IDLE: begin
                if (anyValid && !tx_busy) begin
                    readyVec[sel] = 1'b1;
                end
            end
            HOLD: readyVec[grantQ] = req_valid[grantQ] & ~tx_busy;
            default: readyVec = '0;
        endcase
    end

    assign req_ready = rst_n ? readyVec : '0;
    assign handshake = |readyVec;
    assign acceptIdx = (state == HOLD) ? grantQ : sel;
    assign nextPtr   = (grantQ == PTR_W'(NUM_REQ - 1)) ? '0 : grantQ + 1'b1;
    assign grant_id  = 3'(grantQ);
    assign active    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState   = state;
        timeoutHit  = 1'b0;
        releaseLast = 1'b0;
        case (state)
            IDLE: begin
                if (handshake) begin
                    nextState = START;
                end
            end
            START: nextState = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy) begin
                    nextState = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (!tx_busy) begin
                    if (lastQ) begin
                        nextState   = IDLE;
                        releaseLast = 1'b1;
                    end else begin
                        nextState = HOLD;
                    end
                end
            end
            HOLD: begin
                if (handshake) begin
                    nextState = START;
                end else if (LOCK_TIMEOUT != 0 && holdCnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    nextState  = IDLE;
                    timeoutHit = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // tx_start is derived from nextState so it is high for exactly the START cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_start     <= 1'b0;
            tx_data      <= 8'h00;
            grantQ       <= '0;
            rrPtr        <= '0;
            lastQ        <= 1'b0;
            holdCnt      <= '0;
            lock_timeout <= 1'b0;
        end else begin
            tx_start     <= (nextState == START);
            lock_timeout <= timeoutHit;
            if (handshake) begin
                tx_data <= reqBytes[acceptIdx];
                lastQ   <= req_last[acceptIdx];
                grantQ  <= acceptIdx;
            end
            if (releaseLast || timeoutHit) begin
                rrPtr <= nextPtr;
            end
            if (state == HOLD && !handshake) begin
                if (holdCnt != '1) begin
                    holdCnt <= holdCnt + 1'b1;
                end
            end else begin
                holdCnt <= '0;
            end
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one async_transmitter between NUM_REQ byte sources: SID register echo, status reporter, debug console, and similar.
- Uses round-robin arbitration with packet locking. A requester that is granted keeps the transmitter until it sends a byte flagged last, or until it stalls past LOCK_TIMEOUT.
- Sits between the requesters and the transmitter's TxD_start/TxD_data/TxD_busy pins. It sequences each byte through the transmitter's start/busy handshake.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LOCK_TIMEOUT, 1024, HOLD cycles before a stalled packet lock is released; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  requester i has a byte
- req_data  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i]
- req_last  in  NUM_REQ  byte of requester i ends its packet
- req_ready  out  NUM_REQ  byte of requester i is accepted this cycle (combinational)
- tx_start  out  1  to transmitter TxD_start
- tx_data  out  8  to transmitter TxD_data
- tx_busy  in  1  from transmitter TxD_busy
- grant_id  out  3  index of the current or most recent owner
- active  out  1  a packet is in progress (any state other than IDLE)
- lock_timeout  out  1  one-cycle pulse when a stalled lock is released

Behaviour:
- Reset values (async, rst_n=0): state=IDLE, tx_start=0, tx_data=0x00, grant_id=0, rr_ptr=0, last_q=0, hold_cnt=0, lock_timeout=0. With rst_n=0, req_ready=0.
- States: IDLE, START, WAIT_BUSY, WAIT_IDLE, HOLD.
- Selection: sel = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
- IDLE:
  - req_ready[sel]=1 only if some req_valid=1 and tx_busy=0; every other bit is 0.
  - On that handshake: tx_data<=req_data[sel], last_q<=req_last[sel], grant_id<=sel, go to START.
- HOLD:
  - req_ready[grant_id]=req_valid[grant_id] & ~tx_busy; all other requesters are blocked.
  - On handshake: load tx_data and last_q, clear hold_cnt, go to START.
  - Otherwise hold_cnt increments.
  - If LOCK_TIMEOUT!=0 and hold_cnt==LOCK_TIMEOUT-1 with no handshake: pulse lock_timeout, set rr_ptr<=grant_id+1 mod NUM_REQ, go to IDLE.
- START: tx_start=1 for exactly this one cycle, then go to WAIT_BUSY. tx_start is registered, so it rises the cycle after the req handshake. tx_data stays stable from START until the next handshake.
- WAIT_BUSY: stay until tx_busy=1, then go to WAIT_IDLE. The transmitter raises busy one cycle after start.
- WAIT_IDLE: stay until tx_busy=0, then:
  - if last_q=1: rr_ptr<=grant_id+1 mod NUM_REQ, go to IDLE;
  - otherwise clear hold_cnt and go to HOLD.
- Throughput: at most one byte per transmitter frame. The earliest next handshake is the cycle after busy falls (IDLE/HOLD evaluated that cycle).
- Simultaneous requests: only sel is accepted; the others wait with req_ready=0 and must hold their data.
- A valid that deasserts before the handshake is simply dropped from selection; no byte is lost.
- Asserting req_last on a single-byte packet releases the lock immediately after that byte.
- If tx_busy is high at IDLE (foreign use, or reset of the arbiter alone), no handshake occurs until it is low.
- Reset mid-frame: the arbiter returns to IDLE immediately. A frame already latched in the transmitter completes; the busy gating above prevents overlap.
- hold_cnt width is clog2(LOCK_TIMEOUT)+1 and it saturates. Wrap of rr_ptr: NUM_REQ-1 → 0.
- No combinational path from tx_busy to tx_start.

Test Plan:
- Single byte:
  - Stimulus: req_valid=0b0100, data 0x5A, last=1.
  - Required: req_ready[2] pulse; tx_start one cycle later; tx_data=0x5A; grant_id=2; after busy falls, state=IDLE and rr_ptr=3.
- Contention:
  - Stimulus: req0 and req1 both valid with last=1 from reset.
  - Required: req0 is served first, then req1; next, with req0 and req1 both valid again, req0 is served after rr_ptr wraps via req1+1=2 (neither 2 nor 3 valid) → req0.
- Packet lock:
  - Stimulus: req1 sends 0x11, 0x22, 0x33 (last on 0x33) while req0 is continuously valid.
  - Required: the three bytes are sent consecutively; req_ready[0]=0 throughout; req0 is granted next.
- Timeout:
  - Stimulus: LOCK_TIMEOUT=16; req3 sends 0xA0 with last=0, then drops valid.
  - Required: lock_timeout pulses 16 cycles after entering HOLD; req1 valid is then granted.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during WAIT_IDLE.
  - Required: all outputs take reset values asynchronously; after release with tx_busy still high, no tx_start until tx_busy=0.
- Back-to-back with the simulation-mode transmitter (one bit per clock):
  - Stimulus: 4 requesters each send one byte.
  - Required: bytes 0..3 appear in index order on TxD with no overlapping frames.
